uart_line_monitor: RTL and testbench

UART_LINE_MONITOR -- requirements
Module: uart_line_monitor

---
 rtl/uart_mon_pkg.sv | 10 +
 rtl/uart_mon_baud_gen.sv | 20 ++
 rtl/uart_line_monitor.sv | 130 +++++++++++++
 tb/tb_uart_line_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: shared types and constants for the UART line monitor.
// Holds the receiver FSM state enum, the 16x oversample constants and the
// baud counter width used by uart_line_monitor and uart_mon_baud_gen.
package uart_mon_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam int OVERSAMPLE = 16;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MID_SAMPLE = OS_W'(7);
    localparam int BAUD_W = 13;
endpackage

// File: rtl/uart_mon_baud_gen.sv
// uart_mon_baud_gen: 16x oversample tick generator.
// Ports: PCLK (clock), PRESET (async active-high reset),
//        tick (one-PCLK pulse every BAUD_VALUE+1 cycles).
module uart_mon_baud_gen
    import uart_mon_pkg::*;
#(
    parameter int BAUD_VALUE = 1
) (
    input  logic PCLK,
    input  logic PRESET,
    output logic tick
);
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == BAUD_W'(BAUD_VALUE);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_line_monitor.sv
// uart_line_monitor: 16x oversampling UART receiver with error flags.
// Ports: PCLK, PRESET (async active-high), RX (serial line, idle high),
//        DATA_ACK (consumer took the byte), DATA_OUT[7:0], DATA_VALID,
//        PARITY_ERR, FRAMING_ERR, OVERFLOW (sticky until DATA_ACK).
// Build option: define UART_MON_MAJORITY_EN to decide each bit by majority
// of the samples at oversample counts 6/7/8 instead of one sample at 7.
module uart_line_monitor
    import uart_mon_pkg::*;
#(
    parameter int BAUD_VALUE = 1,
    parameter int BIT8       = 1,
    parameter int PARITY_EN  = 0,
    parameter int ODD_N_EVEN = 0
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       RX,
    input  logic       DATA_ACK,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW
);
    state_e state_q, state_d;
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic [OS_W-1:0] os_q, os_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, byte_w, dout_q, dout_d;
    logic par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic tick, fall, dec, bit_val, last_bit, shift_en, par_en, load, ack_eff;

    uart_mon_baud_gen #(.BAUD_VALUE(BAUD_VALUE)) u_baud (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .tick  (tick)
    );

`ifdef UART_MON_MAJORITY_EN
    logic [1:0] maj_q, maj_d;
    assign maj_d = (tick && os_q == MID_SAMPLE - 1'b1) ? {maj_q[1], rx_s2_q} :
                   (tick && os_q == MID_SAMPLE)        ? {rx_s2_q, maj_q[0]} : maj_q;
    assign dec     = tick && os_q == MID_SAMPLE + 1'b1;
    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s2_q) | (maj_q[1] & rx_s2_q);
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) maj_q <= '1;
        else        maj_q <= maj_d;
    end
`else
    assign dec     = tick && os_q == MID_SAMPLE;
    assign bit_val = rx_s2_q;
`endif

    // Edge-triggered start: a line held low after a break never restarts a frame.
    assign fall     = rx_prev_q & ~rx_s2_q;
    assign last_bit = bit_q == ((BIT8 != 0) ? 3'd7 : 3'd6);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (dec) state_d = bit_val ? IDLE : DATA;
            DATA:    if (dec && last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (dec) state_d = STOP;
            STOP:    if (dec) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_en = dec && state_q == DATA;
        par_en   = dec && state_q == PARITY;
        load     = dec && state_q == STOP;
    end

    // Oversample counter wraps at 16, which is the bit boundary.
    assign os_d    = (state_q == IDLE) ? '0 : os_q + OS_W'(tick);
    assign bit_d   = (state_q != DATA) ? '0 : bit_q + 3'(shift_en);
    assign sh_d    = shift_en ? {bit_val, sh_q[7:1]} : sh_q;
    assign byte_w  = (BIT8 != 0) ? sh_q : {1'b0, sh_q[7:1]};
    assign par_d   = (state_q == IDLE) ? 1'b0 :
                     par_en ? (^byte_w ^ bit_val ^ (ODD_N_EVEN != 0)) : par_q;
    assign ack_eff = DATA_ACK & valid_q;
    assign valid_d = load | (valid_q & ~ack_eff);
    assign dout_d  = load ? byte_w : dout_q;
    assign perr_d  = load ? par_q : perr_q & ~ack_eff;
    assign ferr_d  = load ? ~bit_val : ferr_q & ~ack_eff;
    assign ovf_d   = ~ack_eff & (ovf_q | (load & valid_q));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            os_q      <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            os_q      <= os_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign DATA_OUT    = dout_q;
    assign DATA_VALID  = valid_q;
    assign PARITY_ERR  = perr_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_uart_line_monitor.sv
// tb_uart_line_monitor: bench for uart_line_monitor (8N1 and 8E1 instances).
module tb_uart_line_monitor;
    localparam int BIT_CYC = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, ack_a = 1'b0, ack_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic val_a, pe_a, fe_a, ov_a, val_b, pe_b, fe_b, ov_b;
    int pass_cnt = 0, total = 0;
    bit pend_m = 0, ovf_m = 0, fe_m = 0;
    logic [7:0] d_m = 8'h00;

    always #5 clk = ~clk;

    uart_line_monitor #(.BAUD_VALUE(1), .BIT8(1), .PARITY_EN(0), .ODD_N_EVEN(0)) dut_a (
        .PCLK(clk), .PRESET(rst), .RX(rx_a), .DATA_ACK(ack_a), .DATA_OUT(dout_a),
        .DATA_VALID(val_a), .PARITY_ERR(pe_a), .FRAMING_ERR(fe_a), .OVERFLOW(ov_a));
    uart_line_monitor #(.BAUD_VALUE(1), .BIT8(1), .PARITY_EN(1), .ODD_N_EVEN(0)) dut_b (
        .PCLK(clk), .PRESET(rst), .RX(rx_b), .DATA_ACK(ack_b), .DATA_OUT(dout_b),
        .DATA_VALID(val_b), .PARITY_ERR(pe_b), .FRAMING_ERR(fe_b), .OVERFLOW(ov_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx_b = b; else rx_a = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // sel=1 targets the parity instance and appends the parity bit.
    task automatic send(input bit sel, input logic [7:0] d, input logic stop, input logic par);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (sel) drive(sel, par);
        drive(sel, stop);
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        ovf_m = ovf_m | pend_m;
        pend_m = 1;
        d_m = d;
        fe_m = !stop;
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_valid"}, val_a, pend_m);
        chk({tag, "_data"}, dout_a, d_m);
        chk({tag, "_ferr"}, fe_a, fe_m);
        chk({tag, "_perr"}, pe_a, 0);
        chk({tag, "_ovf"}, ov_a, ovf_m);
    endtask

    task automatic do_ack_a();
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        @(negedge clk);
        if (pend_m) begin
            pend_m = 0;
            ovf_m = 0;
            fe_m = 0;
        end
    endtask

    task automatic do_ack_b();
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        logic p, s;
        repeat (3) @(negedge clk);
        chk("rst_a", {dout_a, val_a, pe_a, fe_a, ov_a}, 0);
        chk("rst_b", {dout_b, val_b, pe_b, fe_b, ov_b}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        lat = 0;
        fork
            send(0, 8'hA5, 1'b1, 1'b0);
            while (!val_a && lat < 400) begin
                @(negedge clk);
                lat++;
            end
        join
        chk("a5_latency", (lat >= 295 && lat <= 325), 1);
        model_frame(8'hA5, 1'b1);
        check_a("a5");
        do_ack_a();
        check_a("a5_ack");

        send(0, 8'h11, 1'b1, 1'b0);
        model_frame(8'h11, 1'b1);
        send(0, 8'h22, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1);
        check_a("ovf");
        do_ack_a();
        check_a("ovf_ack");

        rx_a = 1'b0;
        repeat (10 * BIT_CYC + 64) @(negedge clk);
        model_frame(8'h00, 1'b0);
        check_a("brk");
        do_ack_a();
        repeat (300) @(negedge clk);
        check_a("brk_hold");
        rx_a = 1'b1;
        repeat (64) @(negedge clk);

        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (100) @(negedge clk);
        check_a("glitch");
        send(0, 8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1);
        check_a("after_glitch");
        do_ack_a();

        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 5) != 0);
            send(0, d, s, 1'b0);
            model_frame(d, s);
            check_a("rnd");
            if ($urandom_range(0, 1) == 1) do_ack_a();
        end
        do_ack_a();

        send(1, 8'h03, 1'b1, 1'b1);
        chk("par1_data", dout_b, 8'h03);
        chk("par1_valid", val_b, 1);
        chk("par1_perr", pe_b, 1);
        chk("par1_ferr", fe_b, 0);
        do_ack_b();
        chk("par_ack_perr", pe_b, 0);
        send(1, 8'h03, 1'b1, 1'b0);
        chk("par0_data", dout_b, 8'h03);
        chk("par0_perr", pe_b, 0);
        do_ack_b();
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            send(1, d, 1'b1, p);
            chk("rndpar_data", dout_b, d);
            chk("rndpar_perr", pe_b, (^d) ^ p);
            chk("rndpar_ovf", ov_b, 0);
            do_ack_b();
        end

        send(0, 8'h77, 1'b1, 1'b0);
        model_frame(8'h77, 1'b1);
        check_a("pre_rst");
        rx_a = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        rx_a = 1'b0;
        repeat (BIT_CYC / 2) @(negedge clk);
        rst = 1'b1;
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        pend_m = 0;
        ovf_m = 0;
        fe_m = 0;
        d_m = 8'h00;
        check_a("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_a("post_rst");
        send(0, 8'h3C, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1);
        check_a("x3c");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
